// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port and IF/ID outputs.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic        out_valid;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, imem_en, out_inst, out_pc4, out_valid, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, imem_en, out_inst, out_pc4, out_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// and hands correct-path instructions with PC+4 to IF/ID, squashing on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_req_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_target;
  logic        w_out_valid;

  function automatic logic [31:0] pc_next(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign w_target    = {bus.redirect_pc[31:2], 2'b00};
  assign w_out_valid = r_req_valid & ~bus.redirect;

  assign bus.imem_addr   = r_pc;
  assign bus.imem_en     = ~bus.stall & ~bus.redirect & ~reset;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_inst    = w_out_valid ? bus.imem_rdata : 32'h0000_0000;
  assign bus.out_pc4     = pc_next(r_req_pc);
  assign bus.fetch_count = r_fetch_count;

  // Priority: reset > redirect > stall > advance. A redirect drops the in-flight
  // fetch, which leaves a one-cycle bubble while the target word is read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (bus.redirect) begin
      r_pc        <= w_target;
      r_req_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc        <= pc_next(r_pc);
      r_req_pc    <= r_pc;
      r_req_valid <= 1'b1;
      if (r_req_valid) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, wrap-around sequence, and a randomized
// stall/redirect stream checked against a queue of expected instructions.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  fetch_stage_if b1 ();
  fetch_stage_if b2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .reset(rst2), .bus(b2));

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous memories that hold their read data while not enabled.
  logic [31:0] m1, m2;
  always @(posedge clk) if (b1.imem_en) m1 <= memw(b1.imem_addr);
  always @(posedge clk) if (b2.imem_en) m2 <= memw(b2.imem_addr);
  assign b1.imem_rdata = m1;
  assign b2.imem_rdata = m2;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, st, rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        en, vld;
    logic [31:0] inst, pc4, cnt;
  } vec_t;
  vec_t vq[$];

  task automatic addv(input logic rst, st, rd, input logic [31:0] rpc, addr,
                      input logic en, vld, input logic [31:0] inst, pc4, cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc; v.addr = addr;
    v.en = en; v.vld = vld; v.inst = inst; v.pc4 = pc4; v.cnt = cnt;
    vq.push_back(v);
  endtask

  typedef struct { logic [31:0] inst, pc4; } exp_t;
  exp_t sb[$];

  initial begin
    //   rst st rd rpc       addr          en vld inst           pc4           cnt
    addv(1, 0, 0, 32'h0,  32'h00, 0, 0, 32'h0,         32'h04, 0); // in reset
    addv(0, 0, 0, 32'h0,  32'h00, 1, 0, 32'h0,         32'h04, 0); // first request
    addv(0, 0, 0, 32'h0,  32'h04, 1, 1, 32'h1000_0000, 32'h04, 0);
    addv(0, 0, 0, 32'h0,  32'h08, 1, 1, 32'h1000_0001, 32'h08, 1);
    addv(0, 1, 0, 32'h0,  32'h0C, 0, 1, 32'h1000_0002, 32'h0C, 2); // stall x3
    addv(0, 1, 0, 32'h0,  32'h0C, 0, 1, 32'h1000_0002, 32'h0C, 2);
    addv(0, 1, 0, 32'h0,  32'h0C, 0, 1, 32'h1000_0002, 32'h0C, 2);
    addv(0, 0, 0, 32'h0,  32'h0C, 1, 1, 32'h1000_0002, 32'h0C, 2);
    addv(0, 0, 0, 32'h0,  32'h10, 1, 1, 32'h1000_0003, 32'h10, 3);
    addv(0, 0, 1, 32'h40, 32'h14, 0, 0, 32'h0,         32'h14, 4); // redirect
    addv(0, 0, 0, 32'h0,  32'h40, 1, 0, 32'h0,         32'h14, 4); // bubble
    addv(0, 0, 0, 32'h0,  32'h44, 1, 1, 32'h1000_0010, 32'h44, 4);
    addv(0, 1, 1, 32'h43, 32'h48, 0, 0, 32'h0,         32'h48, 5); // redirect+stall
    addv(0, 0, 0, 32'h0,  32'h40, 1, 0, 32'h0,         32'h48, 5);
    addv(0, 0, 0, 32'h0,  32'h44, 1, 1, 32'h1000_0010, 32'h44, 5);
    addv(0, 0, 1, 32'h80, 32'h48, 0, 0, 32'h0,         32'h48, 6);
    addv(0, 1, 0, 32'h0,  32'h80, 0, 0, 32'h0,         32'h48, 6); // stalled bubble
    addv(0, 1, 0, 32'h0,  32'h80, 0, 0, 32'h0,         32'h48, 6);
    addv(1, 1, 0, 32'h0,  32'h80, 0, 0, 32'h0,         32'h48, 6); // reset wins
    addv(0, 0, 0, 32'h0,  32'h00, 1, 0, 32'h0,         32'h04, 0);
    addv(0, 0, 0, 32'h0,  32'h04, 1, 1, 32'h1000_0000, 32'h04, 0);
    addv(0, 0, 0, 32'h0,  32'h08, 1, 1, 32'h1000_0001, 32'h08, 1);

    rst1 = 1'b1; b1.stall = 1'b0; b1.redirect = 1'b0; b1.redirect_pc = '0;
    rst2 = 1'b1; b2.stall = 1'b0; b2.redirect = 1'b0; b2.redirect_pc = '0;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      rst1 = vq[i].rst; b1.stall = vq[i].st; b1.redirect = vq[i].rd;
      b1.redirect_pc = vq[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d.addr", i),  b1.imem_addr,          vq[i].addr);
      chk($sformatf("v%0d.en", i),    {31'd0, b1.imem_en},   {31'd0, vq[i].en});
      chk($sformatf("v%0d.valid", i), {31'd0, b1.out_valid}, {31'd0, vq[i].vld});
      chk($sformatf("v%0d.inst", i),  b1.out_inst,           vq[i].inst);
      chk($sformatf("v%0d.pc4", i),   b1.out_pc4,            vq[i].pc4);
      chk($sformatf("v%0d.count", i), b1.fetch_count,        vq[i].cnt);
      @(posedge clk); #1;
    end

    // Wrap-around from RESET_PC = 0xFFFF_FFF8.
    rst2 = 1'b0;
    @(negedge clk);
    chk("wrap1.addr", b2.imem_addr, 32'hFFFF_FFF8);
    chk("wrap1.valid", {31'd0, b2.out_valid}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("wrap2.addr", b2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap2.inst", b2.out_inst, 32'h4FFF_FFFE);
    chk("wrap2.pc4", b2.out_pc4, 32'hFFFF_FFFC);
    @(posedge clk); #1; @(negedge clk);
    chk("wrap3.addr", b2.imem_addr, 32'h0000_0000);
    chk("wrap3.inst", b2.out_inst, 32'h4FFF_FFFF);
    chk("wrap3.pc4", b2.out_pc4, 32'h0000_0000);
    @(posedge clk); #1; @(negedge clk);
    chk("wrap4.inst", b2.out_inst, 32'h1000_0000);
    chk("wrap4.pc4", b2.out_pc4, 32'h0000_0004);

    // Randomized stream on dut1 with a scoreboard of expected deliveries.
    @(posedge clk); #1;
    rst1 = 1'b1; b1.stall = 1'b0; b1.redirect = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b0;
    begin
      logic [31:0] k;
      int unsigned cnt;
      logic st, rd;
      exp_t e;
      k = 32'h0;
      cnt = 0;
      sb.delete();
      for (int n = 0; n < 300; n++) begin
        st = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 19) == 0);
        b1.stall = st; b1.redirect = rd;
        b1.redirect_pc = ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
        @(negedge clk);
        chk($sformatf("s%0d.en", n), {31'd0, b1.imem_en}, {31'd0, ~st & ~rd});
        chk($sformatf("s%0d.addr", n), b1.imem_addr, k);
        chk($sformatf("s%0d.valid", n), {31'd0, b1.out_valid},
            {31'd0, (sb.size() > 0) && !rd});
        chk($sformatf("s%0d.count", n), b1.fetch_count, cnt);
        if (b1.out_valid && sb.size() > 0) begin
          chk($sformatf("s%0d.inst", n), b1.out_inst, sb[0].inst);
          chk($sformatf("s%0d.pc4", n), b1.out_pc4, sb[0].pc4);
          if (!st) begin
            void'(sb.pop_front());
            cnt++;
          end
        end else if (!b1.out_valid) begin
          chk($sformatf("s%0d.nop", n), b1.out_inst, 32'h0);
        end
        if (rd) begin
          sb.delete();
          k = {b1.redirect_pc[31:2], 2'b00};
        end else if (!st) begin
          e.inst = memw(k);
          e.pc4 = k + 32'd4;
          sb.push_back(e);
          k = k + 32'd4;
        end
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
